host_loader: RTL and testbench

HOST_LOADER -- requirements
Module: host_loader

---
 rtl/tpu_pkg.sv | 18 +
 rtl/byte_pair_assembler.sv | 38 +++
 rtl/host_loader.sv | 140 ++++++++++++++
 tb/tb_host_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: memory depths, write-address width, loader state enum.
package tpu_pkg;

  localparam int unsigned W_DEPTH   = 4;
  localparam int unsigned INP_DEPTH = 4;
  localparam int unsigned INS_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;

  localparam int unsigned W_CNT_W   = $clog2(W_DEPTH);
  localparam int unsigned INP_CNT_W = $clog2(INP_DEPTH);
  localparam int unsigned INS_CNT_W = $clog2(INS_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs two host bytes (low first, then high) into one 16-bit instruction word.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        pending
);

  logic       phase;
  logic [7:0] low_byte;

  // Phase toggles on every accepted byte; the low byte is held until its partner arrives.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase    <= 1'b0;
      low_byte <= '0;
    end else if (byte_valid) begin
      if (!phase) begin
        low_byte <= byte_in;
        phase    <= 1'b1;
      end else begin
        phase    <= 1'b0;
      end
    end
  end

  // The word is complete in the same cycle the high byte is presented.
  always_comb begin
    word       = {byte_in, low_byte};
    word_valid = byte_valid && phase;
    pending    = phase;
  end

endmodule

// File: rtl/host_loader.sv
// Host loader: writes weight/input/instruction memories from host bytes and
// launches the control unit. Optional macro HOST_LOADER_CHK_EN gates start on
// all three regions having been fully loaded.
module host_loader
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              fetch_w,
  input  logic              fetch_inp,
  input  logic              fetch_ins,
  input  logic              start,
  input  logic              done,
  output logic              w_we,
  output logic              inp_we,
  output logic              ins_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              run,
  output logic              busy,
  output logic              err
);

  loader_state_t state, state_next;

  logic [W_CNT_W-1:0]   w_cnt;
  logic [INP_CNT_W-1:0] inp_cnt;
  logic [INS_CNT_W-1:0] ins_cnt;

  logic multi, any_flag, start_ok;
  logic do_w, do_inp, do_ins, do_start, err_set;
  logic [15:0] ins_word;
  logic ins_valid, ins_pending;

`ifdef HOST_LOADER_CHK_EN
  logic w_loaded, inp_loaded, ins_loaded;
  assign start_ok = w_loaded && inp_loaded && ins_loaded;
`else
  assign start_ok = 1'b1;
`endif

  assign multi    = $countones({fetch_w, fetch_inp, fetch_ins, start}) > 1;
  assign any_flag = fetch_w || fetch_inp || fetch_ins || start;

  byte_pair_assembler u_bpa (
    .clk        (clk),
    .reset      (reset),
    .clear      (do_start),
    .byte_valid (do_ins),
    .byte_in    (data_in),
    .word       (ins_word),
    .word_valid (ins_valid),
    .pending    (ins_pending)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: accepted start launches a run, done ends it.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start && !multi && start_ok) state_next = RUN;
      RUN:  if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command decode: only single flags in IDLE act; everything else can only raise err.
  always_comb begin
    busy     = (state == RUN);
    do_w     = (state == IDLE) && !multi && fetch_w;
    do_inp   = (state == IDLE) && !multi && fetch_inp;
    do_ins   = (state == IDLE) && !multi && fetch_ins;
    do_start = (state == IDLE) && !multi && start && start_ok;
    err_set  = multi
            || ((state == RUN) && any_flag)
            || ((state == IDLE) && start && (ins_pending || !start_ok));
  end

  // Registered write port, counters, run pulse and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_we    <= 1'b0;
      inp_we  <= 1'b0;
      ins_we  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      run     <= 1'b0;
      err     <= 1'b0;
      w_cnt   <= '0;
      inp_cnt <= '0;
      ins_cnt <= '0;
`ifdef HOST_LOADER_CHK_EN
      w_loaded   <= 1'b0;
      inp_loaded <= 1'b0;
      ins_loaded <= 1'b0;
`endif
    end else begin
      w_we    <= do_w;
      inp_we  <= do_inp;
      ins_we  <= ins_valid;
      wr_addr <= '0;
      wr_data <= '0;
      run     <= do_start;
      err     <= err || err_set;
      if (do_start) begin
        w_cnt   <= '0;
        inp_cnt <= '0;
        ins_cnt <= '0;
      end else if (do_w) begin
        wr_addr <= ADDR_W'(w_cnt);
        wr_data <= {8'h00, data_in};
        w_cnt   <= (w_cnt == W_CNT_W'(W_DEPTH - 1)) ? '0 : w_cnt + 1'b1;
`ifdef HOST_LOADER_CHK_EN
        if (w_cnt == W_CNT_W'(W_DEPTH - 1)) w_loaded <= 1'b1;
`endif
      end else if (do_inp) begin
        wr_addr <= ADDR_W'(inp_cnt);
        wr_data <= {8'h00, data_in};
        inp_cnt <= (inp_cnt == INP_CNT_W'(INP_DEPTH - 1)) ? '0 : inp_cnt + 1'b1;
`ifdef HOST_LOADER_CHK_EN
        if (inp_cnt == INP_CNT_W'(INP_DEPTH - 1)) inp_loaded <= 1'b1;
`endif
      end else if (ins_valid) begin
        wr_addr <= ADDR_W'(ins_cnt);
        wr_data <= ins_word;
        ins_cnt <= (ins_cnt == INS_CNT_W'(INS_DEPTH - 1)) ? '0 : ins_cnt + 1'b1;
`ifdef HOST_LOADER_CHK_EN
        if (ins_cnt == INS_CNT_W'(INS_DEPTH - 1)) ins_loaded <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_host_loader.sv
// Scoreboard bench for host_loader: driver pushes expected outputs from a
// behavioural model, monitor pops and compares one record per clock.
module tb_host_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = '0;
  logic        fetch_w = 1'b0, fetch_inp = 1'b0, fetch_ins = 1'b0, start = 1'b0, done = 1'b0;
  logic        w_we, inp_we, ins_we, run, busy, err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  host_loader dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .fetch_w(fetch_w), .fetch_inp(fetch_inp), .fetch_ins(fetch_ins),
    .start(start), .done(done),
    .w_we(w_we), .inp_we(inp_we), .ins_we(ins_we),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        run;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  bit      m_run;
  int      m_cnt[3];          // 0 weights, 1 inputs, 2 instructions
  int      m_depth[3] = '{4, 4, 16};
  bit      m_loaded[3];
  bit      m_pend;
  bit [7:0] m_low;
  bit      m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_write(input int r, input logic [15:0] d, inout exp_t e);
    e.we[2 - r] = 1'b1;
    e.addr = 4'(m_cnt[r]);
    e.data = d;
    m_cnt[r] = (m_cnt[r] + 1) % m_depth[r];
    if (m_cnt[r] == 0) m_loaded[r] = 1'b1;
  endfunction

  // One clock of stimulus: drive on the falling edge, predict the post-edge outputs.
  task automatic cyc(input bit r, input bit fw, input bit fi, input bit fs,
                     input bit st, input bit dn, input logic [7:0] d);
    exp_t e;
    int nflags;
    bit ok;
    @(negedge clk);
    reset = r; fetch_w = fw; fetch_inp = fi; fetch_ins = fs; start = st; done = dn; data_in = d;
    e.we = '0; e.addr = '0; e.data = '0; e.run = 1'b0;
    nflags = int'(fw) + int'(fi) + int'(fs) + int'(st);
`ifdef HOST_LOADER_CHK_EN
    ok = m_loaded[0] && m_loaded[1] && m_loaded[2];
`else
    ok = 1'b1;
`endif
    if (r) begin
      m_run = 0; m_cnt = '{0, 0, 0}; m_loaded = '{0, 0, 0}; m_pend = 0; m_err = 0;
    end else if (!m_run) begin
      if (nflags > 1) m_err = 1;
      else if (fw) model_write(0, {8'h00, d}, e);
      else if (fi) model_write(1, {8'h00, d}, e);
      else if (fs) begin
        if (!m_pend) begin m_low = d; m_pend = 1; end
        else begin model_write(2, {d, m_low}, e); m_pend = 0; end
      end else if (st) begin
        if (ok) begin
          if (m_pend) m_err = 1;
          m_pend = 0; m_cnt = '{0, 0, 0}; m_run = 1; e.run = 1'b1;
        end else m_err = 1;
      end
    end else begin
      if (nflags > 0) m_err = 1;
      if (dn) m_run = 0;
    end
    e.busy = m_run;
    e.err  = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a full output record; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("strobes", {29'd0, w_we, inp_we, ins_we}, {29'd0, e.we});
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
        check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
        check("run/busy/err", {29'd0, run, busy, err}, {29'd0, e.run, e.busy, e.err});
      end
    end
  end

  initial begin
    int op;
    bit dn;
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    // Weight load 0x11..0x44, addresses 0..3
    cyc(0, 1, 0, 0, 0, 0, 8'h11);
    cyc(0, 1, 0, 0, 0, 0, 8'h22);
    cyc(0, 1, 0, 0, 0, 0, 8'h33);
    cyc(0, 1, 0, 0, 0, 0, 8'h44);
    // Instruction assembly 0xCD, 0xAB -> 0xABCD
    cyc(0, 0, 0, 1, 0, 0, 8'hCD);
    cyc(0, 0, 0, 1, 0, 0, 8'hAB);
    // Input wrap: 5 writes -> 0,1,2,3,0
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 8'(8'h50 + i));
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    // Run, illegal fetch in run, done
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 8'h77);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    // Reset mid-run, then a weight write lands at address 0
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 8'h99);
    // Pending low byte at start, multi-flag cycle
    cyc(0, 0, 0, 1, 0, 0, 8'h12);
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 0, 0, 8'h34);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
`ifdef HOST_LOADER_CHK_EN
    // Start before full loads is rejected; after full loads it launches.
    cyc(0, 1, 0, 0, 0, 0, 8'h01);
    cyc(0, 1, 0, 0, 0, 0, 8'h02);
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 8'(i));
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 8'(i));
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 1, 0, 0, 8'(i));
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 8'h00);
`endif
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op = int'($urandom_range(0, 99));
      dn = m_run ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
      if (op < 2) cyc(1, 0, 0, 0, 0, dn, 8'($urandom));
      else if (m_run && op < 90) cyc(0, 0, 0, 0, 0, dn, 8'($urandom));
      else if (op < 30) cyc(0, 1, 0, 0, 0, dn, 8'($urandom));
      else if (op < 50) cyc(0, 0, 1, 0, 0, dn, 8'($urandom));
      else if (op < 78) cyc(0, 0, 0, 1, 0, dn, 8'($urandom));
      else if (op < 83) cyc(0, 0, 0, 0, 1, dn, 8'($urandom));
      else if (op < 86) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), dn, 8'($urandom));
      else cyc(0, 0, 0, 0, 0, dn, 8'($urandom));
    end
    @(negedge clk);
    reset = 1'b0; fetch_w = 0; fetch_inp = 0; fetch_ins = 0; start = 0; done = 0;
    @(posedge clk); #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
